// File: rtl/fad_ctrl_pkg.sv
// Shared types and default sizing for the FIR/decimate capture sequencer.
package fad_ctrl_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CNT_WIDTH    = 16;
    localparam int DEF_GAP_CYCLES   = 4;
    localparam int DEF_CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        GAP,
        DONE,
        ABORT
    } fad_ctrl_state_t;

endpackage

// File: rtl/fad_capture_ctrl_if.sv
// Ready/valid sample stream from the ADC capture path into the sequencer.
interface fad_capture_ctrl_if import fad_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                         src_valid;
    logic                         src_ready;
    logic signed [DATA_WIDTH-1:0] src_data;

    modport master (output src_valid, output src_data, input src_ready);
    modport slave  (input src_valid, input src_data, output src_ready);
endinterface

// File: rtl/fad_capture_ctrl.sv
// Capture sequencer: clears the filter, paces samples in with a minimum gap,
// and counts decimated outputs until the programmed target or an abort.
module fad_capture_ctrl import fad_ctrl_pkg::*; #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CNT_WIDTH-1:0]         num_out,
    fad_capture_ctrl_if.slave            src,
    output logic                         dp_clear,
    output logic                         dp_valid_in,
    output logic signed [DATA_WIDTH-1:0] dp_data_in,
    input  logic                         dp_valid_out,
    input  logic signed [DATA_WIDTH-1:0] dp_data_out,
    output logic                         cap_valid,
    output logic signed [DATA_WIDTH-1:0] cap_data,
    output logic [CNT_WIDTH-1:0]         out_count,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted
);
    localparam int GW  = $clog2(GAP_CYCLES);
    localparam int CLW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    fad_ctrl_state_t      state;
    logic [CNT_WIDTH-1:0] target;
    logic [GW-1:0]        gap_cnt;
    logic [CLW-1:0]       clr_cnt;
    logic                 cnt_hit, hs, cap_en, abort_ok;

    // Once the last output is counted, the source is closed off while the
    // FSM spends one cycle moving to DONE.
    assign cnt_hit       = (out_count == target);
    assign src.src_ready = (state == FEED) && !abort && !cnt_hit;
    assign hs            = src.src_valid && src.src_ready;
    assign cap_en        = (state == FEED) || (state == GAP);
    assign abort_ok      = abort && ((state == CLEAR) || cap_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            target      <= '0;
            gap_cnt     <= '0;
            clr_cnt     <= '0;
            dp_clear    <= 1'b0;
            dp_valid_in <= 1'b0;
            dp_data_in  <= '0;
            cap_valid   <= 1'b0;
            cap_data    <= '0;
            out_count   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            dp_valid_in <= 1'b0;
            cap_valid   <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;

            if (cap_en && dp_valid_out && (out_count < target)) begin
                cap_valid <= 1'b1;
                cap_data  <= dp_data_out;
                out_count <= out_count + 1'b1;
            end

            // A sample accepted on the final-count cycle still goes out.
            if (hs) begin
                dp_data_in  <= src.src_data;
                dp_valid_in <= 1'b1;
            end

            if (abort_ok) begin
                state    <= ABORT;
                dp_clear <= 1'b1;
                aborted  <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        target    <= num_out;
                        out_count <= '0;
                        clr_cnt   <= '0;
                        dp_clear  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CLEAR;
                    end
                    CLEAR: begin
                        if (clr_cnt == CLW'(CLEAR_CYCLES - 1)) begin
                            dp_clear <= 1'b0;
                            if (target == '0) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= FEED;
                            end
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                    FEED: begin
                        if (cnt_hit) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (hs) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                    GAP: begin
                        if (cnt_hit) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (gap_cnt == GW'(GAP_CYCLES - 2)) begin
                            state <= FEED;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    ABORT: begin
                        dp_clear <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
